// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - request/response handshake bundle for memory_responder
//
// Signals:
//   req_valid, req_ready, req_write, req_addr, req_wdata  request channel
//   rsp_valid, rsp_ready, rsp_rdata, rsp_was_write        response channel
// Modports:
//   master - requester side (drives the request, consumes the response)
//   slave  - memory side (memory_responder)
interface memory_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_was_write;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_was_write
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_was_write
    );
endinterface

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - word-addressed memory responder with wait states
//
// Serves one read or write at a time: accept in IDLE, WAIT_CYCLES extra
// cycles in ACCESS, then hold the response in RESP until rsp_ready.
// Optional macro MEM_CLEAR_ON_RESET_EN: reset enters a CLEAR state that
// zeroes every word, one per cycle, before returning to IDLE.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high
//   bus    slave modport of memory_responder_if (request + response channels)
//   busy   out  high whenever the state is not IDLE
module memory_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    memory_responder_if.slave       bus,
    output logic                    busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef MEM_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

    state_t                state;
    logic [3:0]            wait_cnt;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  req_ready_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_was_write_q;
    logic                  busy_q;
    logic                  accept;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

`ifdef MEM_CLEAR_ON_RESET_EN
    logic [ADDR_WIDTH-1:0] clr_addr;
`endif

    assign bus.req_ready     = req_ready_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_was_write = rsp_was_write_q;
    assign busy              = busy_q;

    // req_ready is only ever high in IDLE, so this is the handshake edge.
    assign accept = (state == IDLE) && bus.req_valid && req_ready_q;

    // Memory array has no reset so it maps onto RAM; a reset edge blocks
    // both the write commit and the clear sweep for that edge.
    always_ff @(posedge clk) begin
        if (!reset && accept && bus.req_write) begin
            mem[bus.req_addr] <= bus.req_wdata;
        end
`ifdef MEM_CLEAR_ON_RESET_EN
        else if (!reset && state == CLEAR) begin
            mem[clr_addr] <= '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt        <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_was_write_q <= 1'b0;
`ifdef MEM_CLEAR_ON_RESET_EN
            state           <= CLEAR;
            clr_addr        <= '0;
            req_ready_q     <= 1'b0;
            busy_q          <= 1'b1;
`else
            state           <= IDLE;
            req_ready_q     <= 1'b1;
            busy_q          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_q        <= bus.req_write;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        wait_cnt    <= 4'(WAIT_CYCLES);
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        // Writes echo their data; the word is already in memory.
                        rsp_rdata_q     <= wr_q ? wdata_q : mem[addr_q];
                        rsp_was_write_q <= wr_q;
                        rsp_valid_q     <= 1'b1;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
`ifdef MEM_CLEAR_ON_RESET_EN
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == {ADDR_WIDTH{1'b1}}) begin
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
